// File: rtl/alu_exec_if.sv
// Valid/ready bus for the ALU execute stage: operation in, registered result out.
// The stage is the slave; whatever feeds operands and drains results is the master.
interface alu_exec_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_alu_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [TAGW-1:0] out_tag;
  logic            out_illegal;

  modport master (
    output in_valid, in_alu_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_alu_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry skid buffer on the result side
// and a saturating debug counter of illegal operation codes.
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int TAGW = 5,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_if.slave       bus,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] tag;
    logic            illegal;
  } entry_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t new_entry;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept;
  logic   complete;

  assign accept   = bus.in_valid && in_ready_q;
  assign complete = out_valid_q && bus.out_ready;

  // NOTE: every field gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    new_entry     = '0;
    new_entry.tag = bus.in_tag;
    case (bus.in_alu_op)
      4'd0:    new_entry.result = bus.in_a + bus.in_b;
      4'd1:    new_entry.result = bus.in_a - bus.in_b;
      4'd2:    new_entry.result = bus.in_a & bus.in_b;
      4'd3:    new_entry.result = bus.in_a | bus.in_b;
      4'd4:    new_entry.result = bus.in_a ^ bus.in_b;
      default: new_entry.illegal = 1'b1;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      // NOTE: the data registers are reset too because out_result/out_tag/
      // out_illegal are visible at the pins and must read zero after reset.
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= new_entry;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && complete) begin
            main_q <= new_entry;
          end else if (accept) begin
            skid_q     <= new_entry;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (complete) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (complete) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= '0;
    end else if (accept && new_entry.illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = main_q.result;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a queue-based occupancy/result model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_alu_exec_stage;
  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cnt_clr;
  logic [CNTW-1:0] illegal_cnt;

  alu_exec_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  alu_exec_stage #(.XLEN(XLEN), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cnt_clr     (cnt_clr),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] tag;
    logic            illegal;
    int              cyc;
  } rec_t;

  rec_t model_q[$];
  rec_t done_q[$];
  int   acc_cyc_q[$];
  int   model_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  rec_t obs;
  rec_t gold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the stage must produce for an operation, straight from the op table.
  function automatic rec_t golden(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [TAGW-1:0] tag);
    rec_t r;
    r.tag     = tag;
    r.illegal = 1'b0;
    r.cyc     = 0;
    case (op)
      4'd0:    r.result = a + b;
      4'd1:    r.result = a - b;
      4'd2:    r.result = a & b;
      4'd3:    r.result = a | b;
      4'd4:    r.result = a ^ b;
      default: begin r.result = '0; r.illegal = 1'b1; end
    endcase
    return r;
  endfunction

  // Per-cycle compare: outputs sampled on the falling edge, when they are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset out_valid", bus.out_valid, 0);
      check("reset in_ready", bus.in_ready, 1);
    end else begin
      check("out_valid vs occupancy", bus.out_valid, model_q.size() > 0);
      check("in_ready vs occupancy", bus.in_ready, model_q.size() < 2);
      check("illegal_cnt", illegal_cnt, model_cnt);
      if (bus.out_valid && model_q.size() > 0) begin
        check("out_result", bus.out_result, model_q[0].result);
        check("out_tag", bus.out_tag, model_q[0].tag);
        check("out_illegal", bus.out_illegal, model_q[0].illegal);
      end
      if (bus.out_valid && bus.out_ready) begin
        obs.result  = bus.out_result;
        obs.tag     = bus.out_tag;
        obs.illegal = bus.out_illegal;
        obs.cyc     = cyc;
        done_q.push_back(obs);
        if (model_q.size() > 0) model_q.delete(0);
      end
      if (bus.in_valid && bus.in_ready) begin
        gold = golden(bus.in_alu_op, bus.in_a, bus.in_b, bus.in_tag);
        model_q.push_back(gold);
        acc_cyc_q.push_back(cyc);
      end
      if (cnt_clr) model_cnt = 0;
      else if (bus.in_valid && bus.in_ready && gold.illegal && model_cnt < 255) model_cnt++;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAGW-1:0] tag);
    int w = 0;
    bus.in_valid  = 1'b1;
    bus.in_alu_op = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("send accepted within budget", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_alu_op = 4'd1;
    bus.in_a      = $urandom;
    bus.in_b      = $urandom;
    bus.in_tag    = 5'h1f;
  endtask

  task automatic drain();
    int w = 0;
    while (model_q.size() > 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain within budget", model_q.size(), 0);
  endtask

  logic [31:0] exp_stream [5] = '{32'd12, 32'hFFFF_FFFE, 32'h00F0_00F0, 32'd3, 32'hFFFF_FFFE};
  logic [31:0] exp_bp     [3] = '{32'd3, 32'd7, 32'd11};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_alu_op = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #23 rst_n = 1'b1;

    // Idle after reset
    @(posedge clk); #1;
    check("idle out_valid", bus.out_valid, 0);
    check("idle in_ready", bus.in_ready, 1);
    check("idle illegal_cnt", illegal_cnt, 0);
    check("idle out_result", bus.out_result, 0);
    check("idle out_tag", bus.out_tag, 0);

    // Streaming, out_ready held high
    done_q.delete(); acc_cyc_q.delete();
    send(4'd0, 32'd5, 32'd7, 5'd1);
    send(4'd1, 32'd3, 32'd5, 5'd2);
    send(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3);
    send(4'd3, 32'd1, 32'd2, 5'd4);
    send(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd5);
    drain();
    check("stream count", done_q.size(), 5);
    for (int i = 0; i < 5 && i < done_q.size(); i++) begin
      check("stream result", done_q[i].result, exp_stream[i]);
      check("stream tag", done_q[i].tag, i + 1);
      check("stream latency", done_q[i].cyc, acc_cyc_q[i] + 1);
    end

    // Back-pressure: two fill main+skid, third is held off
    done_q.delete();
    bus.out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2, 5'd6);
    send(4'd0, 32'd3, 32'd4, 5'd7);
    check("bp in_ready low when full", bus.in_ready, 0);
    fork
      send(4'd0, 32'd5, 32'd6, 5'd8);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("bp in_ready held low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp count", done_q.size(), 3);
    for (int i = 0; i < 3 && i < done_q.size(); i++) begin
      check("bp result", done_q[i].result, exp_bp[i]);
      check("bp tag", done_q[i].tag, i + 6);
    end

    // Illegal op codes and saturation
    done_q.delete();
    send(4'd15, 32'd9, 32'd9, 5'd9);
    send(4'd7, 32'd9, 32'd9, 5'd10);
    drain();
    check("illegal count", done_q.size(), 2);
    for (int i = 0; i < 2 && i < done_q.size(); i++) begin
      check("illegal result", done_q[i].result, 0);
      check("illegal flag", done_q[i].illegal, 1);
      check("illegal tag", done_q[i].tag, i + 9);
    end
    check("illegal_cnt after two", illegal_cnt, 2);
    for (int i = 0; i < 260; i++) send(4'(5 + (i % 11)), i, ~i, 5'(i));
    drain();
    check("illegal_cnt saturated", illegal_cnt, 255);
    cnt_clr = 1'b1;
    send(4'd15, 32'd1, 32'd1, 5'd0);
    cnt_clr = 1'b0;
    check("clr beats increment", illegal_cnt, 0);
    drain();

    // Wrap-around
    done_q.delete();
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd11);
    send(4'd1, 32'd0, 32'd1, 5'd12);
    drain();
    check("wrap count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("add wrap", done_q[0].result, 32'h0);
      check("sub wrap", done_q[1].result, 32'hFFFF_FFFF);
    end

    // Asynchronous reset while both entries are full
    bus.out_ready = 1'b0;
    send(4'd9, 32'd1, 32'd1, 5'd13);
    send(4'd0, 32'd2, 32'd2, 5'd14);
    check("pre-reset in_ready", bus.in_ready, 0);
    check("pre-reset illegal_cnt", illegal_cnt, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_q.delete();
    model_cnt = 0;
    #1;
    check("async reset out_valid", bus.out_valid, 0);
    check("async reset in_ready", bus.in_ready, 1);
    check("async reset out_result", bus.out_result, 0);
    check("async reset out_tag", bus.out_tag, 0);
    check("async reset out_illegal", bus.out_illegal, 0);
    check("async reset illegal_cnt", illegal_cnt, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    done_q.delete();
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no stale results", done_q.size(), 0);
    check("post-reset out_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that sits directly downstream of the ALU-control decoder. It accepts a 4-bit ALU operation code plus two 32-bit operands and a destination tag over a valid/ready handshake, and computes the result. It presents the result one cycle later on a registered valid/ready output through a 2-entry skid buffer, so it sustains full throughput under back-pressure. It flags illegal operation codes and keeps a saturating count of them for debug.

## Interface
- XLEN, 32, operand/result width
- TAGW, 5, destination-register tag width
- CNTW, 8, illegal-op counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  stage can accept; registered (no combinational path from out_ready)
- in_alu_op  in  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR; 5–15 illegal (15 is decoder default)
- in_a  in  XLEN  operand A (rs1)
- in_b  in  XLEN  operand B (rs2 or immediate)
- in_tag  in  TAGW  destination tag, passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  XLEN  computed result
- out_tag  out  TAGW  tag of this result
- out_illegal  out  1  operation code was illegal
- illegal_cnt  out  CNTW  count of accepted illegal operations, saturating
- cnt_clr  in  1  synchronous clear of illegal_cnt

## Operation
- Accept when in_valid && in_ready. Complete when out_valid && out_ready.
- Compute at acceptance, using modulo 2^XLEN arithmetic:
  - ADD: a+b
  - SUB: a−b
  - AND: a&b
  - OR: a|b
  - XOR: a^b
- Carry/borrow is discarded.
- Illegal codes (5–15): result=0, out_illegal=1, tag still passed through.
- Storage: main register (drives outputs) and skid register.
- States:
  - EMPTY: out_valid=0, in_ready=1
  - ONE: main valid, in_ready=1
  - TWO: main and skid valid, in_ready=0
- Transitions:
  - EMPTY, accept → ONE (entry loads main).
  - ONE, accept and complete → ONE (new entry replaces main).
  - ONE, accept without complete → TWO (new entry loads skid).
  - ONE, complete without accept → EMPTY.
  - ONE, neither → ONE (hold).
  - TWO, complete → ONE (skid moves to main; no accept possible since in_ready=0).
  - TWO, no complete → TWO (hold).
- Results emerge strictly in acceptance order. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_result, out_tag and out_illegal are stable.
- illegal_cnt:
  - Increments by 1 on each accepted illegal operation.
  - Saturates at 2^CNTW−1.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset (asynchronous, any time including mid-transfer): state EMPTY, both entries invalidated. Outputs: out_valid=0, in_ready=1, out_result=0, out_tag=0, out_illegal=0, illegal_cnt=0.

## Timing
- Latency: 1 cycle from acceptance edge to out_valid=1 with that result.
- Throughput: 1 op/cycle while out_ready=1 continuously.
- in_ready is a flop output (=!skid_valid). It is at least one cycle after out_ready falls, and deasserts only after the skid fills.
- in_ready reasserts in the cycle after the completion that drains the skid.
- Input signals may change freely when in_ready=0; they are ignored.
- Operation is fully synchronous except reset deassertion. The integrator provides a reset synchroniser upstream.

## Test plan
- Reset, then no stimulus → out_valid=0, in_ready=1, illegal_cnt=0, out_result=0.
- Streaming with out_ready=1: ADD 5+7, SUB 3−5, AND F0F0_F0F0&0FF0_0FF0, OR 1|2, XOR FFFF_FFFF^1, tags 1..5 → back-to-back results 12, FFFF_FFFE, 00F0_00F0, 3, FFFF_FFFE, tags 1..5, one cycle after each accept.
- Back-pressure: out_ready=0 while issuing 3 ADDs → first two accepted, in_ready=0 on cycle 3, third held. Releasing out_ready → all three in order, none lost.
- Illegal ops: codes 15 then 7 with a=9, b=9 → out_result=0, out_illegal=1 both times, illegal_cnt=2. Then 260 more illegal ops → illegal_cnt=255. cnt_clr together with an illegal accept → illegal_cnt=0.
- Wrap-around: ADD FFFF_FFFF+1 → 0. SUB 0−1 → FFFF_FFFF.
- Reset asserted while in TWO → out_valid=0 and in_ready=1 asynchronously. After release, no stale results appear.
